sseg_scanner: RTL and testbench

SSEG_SCANNER -- requirements
Module: sseg_scanner

---
 rtl/sseg_pkg.sv | 24 ++
 rtl/sseg_hex_decode.sv | 17 +
 rtl/sseg_scanner.sv | 153 +++++++++++++++
 tb/tb_sseg_scanner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// ----------------------------------------------------------------------------
// sseg_pkg: shared types and constants for the seven-segment scanner. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sseg_pkg;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a}; entry 15 is leftmost in the concatenation.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

`default_nettype wire

// File: rtl/sseg_hex_decode.sv
// ----------------------------------------------------------------------------
// sseg_hex_decode: combinational hex nibble to active-low segment decode. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

`default_nettype wire

// File: rtl/sseg_scanner.sv
// ----------------------------------------------------------------------------
// sseg_scanner: 4-digit multiplexed seven-segment scanner with blanking. Rev 1.0
// Optional macro SSEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits 3..1.
// ----------------------------------------------------------------------------
`default_nettype none

module sseg_scanner
  import sseg_pkg::*;
#(
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_clk,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam bit         NO_BLANK   = (BLANK_CYCLES == 0);
  localparam logic [7:0] BLANK_LAST = NO_BLANK ? 8'd0 : 8'(BLANK_CYCLES - 1);

  logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [1:0]  warm_q, warm_d;
  logic        arm_q, arm_d;
  logic [1:0]  dig_q, dig_d;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [3:0]  pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic        frame_done_q, frame_done_d;

  logic        scan_tick;
  logic        wrap;
  logic [3:0]  nibble;
  logic [6:0]  dec_seg;
  logic        lead_zero;

  // A tick needs a synchronised low seen after reset, so a level held high
  // through reset release never looks like an edge.
  assign scan_tick = arm_q & sync2_q & ~prev_q;
  assign wrap      = scan_tick & (dig_q == 2'd3);
  assign nibble    = disp_val_d[{dig_d, 2'b00} +: 4];

  sseg_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    sync1_d    = scan_clk;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    warm_d     = {warm_q[0], 1'b1};
    arm_d      = arm_q | (warm_q[1] & ~sync2_q);
    pend_val_d = load ? value : pend_val_q;
    pend_dp_d  = load ? dp_in : pend_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    dig_d      = dig_q;
    state_d    = state_q;
    cnt_d      = cnt_q;

    if (wrap) begin
      disp_val_d = load ? value : pend_val_q;
      disp_dp_d  = load ? dp_in : pend_dp_q;
    end

    if (scan_tick) begin
      dig_d   = dig_q + 2'd1;
      cnt_d   = 8'd0;
      state_d = NO_BLANK ? ST_DRIVE : ST_BLANK;
    end else if (state_q == ST_BLANK) begin
      if (NO_BLANK || cnt_q == BLANK_LAST) begin
        state_d = ST_DRIVE;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
`ifdef SSEG_LEADING_ZERO_BLANK_EN
    lead_zero = (dig_d != 2'd0) && ((disp_val_d >> {dig_d, 2'b00}) == 16'd0);
`else
    lead_zero = 1'b0;
`endif
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    dp_d         = 1'b1;
    frame_done_d = wrap;
    if (state_d == ST_DRIVE) begin
      an_d  = ~(4'b0001 << dig_d);
      seg_d = lead_zero ? SEG_OFF : dec_seg;
      dp_d  = ~disp_dp_d[dig_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      warm_q       <= 2'b00;
      arm_q        <= 1'b0;
      dig_q        <= 2'd0;
      state_q      <= ST_BLANK;
      cnt_q        <= 8'd0;
      pend_val_q   <= 16'd0;
      pend_dp_q    <= 4'd0;
      disp_val_q   <= 16'd0;
      disp_dp_q    <= 4'd0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      warm_q       <= warm_d;
      arm_q        <= arm_d;
      dig_q        <= dig_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_sseg_scanner.sv
// ----------------------------------------------------------------------------
// tb_sseg_scanner: scanner bench, BLANK_CYCLES=16 and 0 instances side by side.
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sseg_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_clk = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'd0;
  logic [3:0]  dp_in = 4'd0;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b, fd_a, fd_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sseg_scanner #(.BLANK_CYCLES(16)) dut_a (
    .clk(clk), .rst(rst), .scan_clk(scan_clk), .value(value), .dp_in(dp_in),
    .load(load), .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a)
  );

  sseg_scanner #(.BLANK_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .scan_clk(scan_clk), .value(value), .dp_in(dp_in),
    .load(load), .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b)
  );

  // Reference model: digit = ticks mod 4, age = clk edges since last tick/reset.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int        since_rst = 0, age = 0, digit = 0;
  bit        in_rst = 1'b1, fd_exp = 1'b0;
  bit [15:0] pend = 16'd0, disp = 16'd0;
  bit [3:0]  pdp = 4'd0, ddp = 4'd0;
  bit        h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  // scan_clk generator
  bit scan_run = 1'b1, scan_rand = 1'b0;
  int scan_hi = 20, scan_lo = 20, scan_ph = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge m applies a tick when scan_clk sampled two edges ago was high and
  // three edges ago low, both samples taken after reset release.
  task automatic model_edge();
    bit tick;
    if (rst) begin
      in_rst = 1'b1; since_rst = 0; age = 0; digit = 0; fd_exp = 1'b0;
      pend = 16'd0; disp = 16'd0; pdp = 4'd0; ddp = 4'd0;
    end else begin
      in_rst = 1'b0;
      since_rst++;
      tick   = (since_rst >= 4) && h2 && !h3;
      fd_exp = tick && (digit == 3);
      if (load) begin pend = value; pdp = dp_in; end
      if (fd_exp) begin disp = pend; ddp = pdp; end
      if (tick) begin digit = (digit + 1) % 4; age = 0; end
      else if (age < 100000) age++;
    end
    h3 = h2; h2 = h1; h1 = scan_clk;
  endtask

  function automatic bit wrap_next();
    return !rst && (since_rst + 1 >= 4) && h2 && !h3 && (digit == 3);
  endfunction

  task automatic expect_out(input int b, output logic [3:0] e_an, output logic [6:0] e_seg,
                            output logic e_dp);
    bit [3:0] nib;
    if (in_rst || age < b) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      nib   = disp[digit*4 +: 4];
      e_an  = ~(4'b0001 << digit);
      e_seg = hex_tab[nib];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      if (digit > 0 && (disp >> (4 * digit)) == 16'd0) e_seg = 7'h7F;
`endif
      e_dp  = ~ddp[digit];
    end
  endtask

  task automatic cyc();
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    if (scan_run) begin
      scan_ph++;
      if (scan_clk && scan_ph >= scan_hi) begin
        scan_clk = 1'b0; scan_ph = 0;
        if (scan_rand) scan_lo = $urandom_range(3, 25);
      end else if (!scan_clk && scan_ph >= scan_lo) begin
        scan_clk = 1'b1; scan_ph = 0;
        if (scan_rand) scan_hi = $urandom_range(3, 25);
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    expect_out(16, ea, es, ed);
    check("an_a", an_a, ea);  check("seg_a", seg_a, es);
    check("dp_a", dp_a, ed);  check("fd_a", fd_a, fd_exp);
    expect_out(0, ea, es, ed);
    check("an_b", an_b, ea);  check("seg_b", seg_b, es);
    check("dp_b", dp_b, ed);  check("fd_b", fd_b, fd_exp);
  endtask

  task automatic watch_frame(input logic [6:0] s0, s1, s2, s3, input logic [3:0] dpx,
                             input string tag);
    logic [6:0] es [4];
    bit         seen [4];
    int         nseen = 0;
    es = '{s0, s1, s2, s3};
    seen = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 200 && nseen < 4; i++) begin
      cyc();
      for (int k = 0; k < 4; k++) begin
        if (an_a === ~(4'b0001 << k) && !seen[k]) begin
          seen[k] = 1'b1;
          nseen++;
          check({tag, "_seg"}, seg_a, es[k]);
          check({tag, "_dp"}, dp_a, dpx[k] ? 1'b0 : 1'b1);
        end
      end
    end
    check({tag, "_digits"}, 16'(nseen), 16'd4);
  endtask

  initial begin
    logic [3:0] seq_exp [5];
    logic [3:0] prev_an;
    int         nseq, run, nf;
    bit         done;

    // Reset
    rst = 1'b1;
    repeat (3) cyc();
    check("rst_an", an_a, 4'hF);
    check("rst_seg", seg_a, 7'h7F);
    check("rst_fd", fd_a, 1'b0);

    // Four-digit scan at 40 clk per scan period: each drive preceded by 16 blanks
    rst = 1'b0; scan_clk = 1'b0; scan_ph = 0;
    seq_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    nseq = 0; run = 0; prev_an = 4'hF;
    for (int i = 0; i < 200 && nseq < 5; i++) begin
      cyc();
      if (an_a === 4'hF) run++;
      else if (prev_an === 4'hF) begin
        check("scan_seq", an_a, seq_exp[nseq]);
        if (nseq > 0) check("blank_len", 16'(run), 16'd16);
        nseq++;
        run = 0;
      end
      prev_an = an_a;
    end
    check("scan_seq_count", 16'(nseq), 16'd5);

    // Mid-frame load: held in pending until the wrap
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (digit == 1) done = 1'b1;
      else cyc();
    end
    check("wait_digit1", 16'(digit), 16'd1);
    value = 16'h1234; dp_in = 4'b0100; load = 1'b1;
    cyc();
    load = 1'b0; value = 16'h0000; dp_in = 4'b0000;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      cyc();
      if (fd_a === 1'b1) done = 1'b1;
    end
    check("wait_fd", fd_a, 1'b1);
    watch_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0100, "f1234");

    // Load on the wrap-tick cycle goes straight to the display
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (wrap_next()) done = 1'b1;
      else cyc();
    end
    check("wait_wrap", 16'(done), 16'd1);
    value = 16'hABCD; dp_in = 4'b0001; load = 1'b1;
    cyc();
    load = 1'b0; value = 16'h0000; dp_in = 4'b0000;
    check("bypass_fd", fd_a, 1'b1);
    watch_frame(7'h21, 7'h46, 7'h03, 7'h08, 4'b0001, "fabcd");

    // Randomised scan periods, loads and one mid-run reset
    scan_rand = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst = (i == 700 || i == 701);
      if ($urandom_range(0, 19) == 0) begin
        load = 1'b1; value = 16'($urandom); dp_in = 4'($urandom);
      end
      cyc();
      load = 1'b0;
    end
    rst = 1'b0;
    scan_rand = 1'b0; scan_hi = 20; scan_lo = 20;

    // Reset while driving digit 2, scan_clk held high across it
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (digit == 2 && an_a === 4'b1011) done = 1'b1;
      else cyc();
    end
    check("wait_drive2", an_a, 4'b1011);
    scan_run = 1'b0; scan_clk = 1'b1; rst = 1'b1;
    cyc();
    check("rst_mid_an", an_a, 4'hF);
    rst = 1'b0;
    repeat (30) cyc();
    check("no_tick_after_rst", an_a, 4'b1110);

    // Scan edges 3 clk apart: the zero-blank instance never goes all-off
    scan_clk = 1'b0; scan_ph = 0; scan_hi = 1; scan_lo = 2; scan_run = 1'b1;
    repeat (4) cyc();
    nf = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (an_b === 4'hF) nf++;
    end
    check("b0_never_off", 16'(nf), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
